// File: rtl/branch_pkg.sv
// Shared definitions for the branch prediction / resolution unit.
//   - branch type encodings carried on branch_type_e
//   - 2-bit direction counter state constants
//   - fall-through PC increment
package branch_pkg;

   typedef enum logic [2:0] {
      NOBRANCH = 3'd0,
      BEQ      = 3'd1,
      BNE      = 3'd2,
      BLT      = 3'd3,
      BLTU     = 3'd4,
      BGE      = 3'd5,
      BGEU     = 3'd6
   } br_type_t;

   // Direction counter: MSB is the predicted direction.
   localparam logic [1:0] CNT_SNT = 2'b00;   // strong not-taken
   localparam logic [1:0] CNT_WNT = 2'b01;   // weak not-taken (reset state)
   localparam logic [1:0] CNT_WT  = 2'b10;   // weak taken (allocation state)
   localparam logic [1:0] CNT_ST  = 2'b11;   // strong taken

   localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator.
// Ports:
//   branch_type  in   3     branch type code (branch_pkg encodings)
//   operand1     in   XLEN  first compare operand
//   operand2     in   XLEN  second compare operand
//   taken        out  1     condition holds; 0 for NOBRANCH and undefined codes
module branch_cond
   import branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      branch_type,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   output logic            taken
);

   logic signed [XLEN-1:0] op1_s;
   logic signed [XLEN-1:0] op2_s;

   assign op1_s = operand1;
   assign op2_s = operand2;

   always_comb begin
      taken = 1'b0;
      case (branch_type)
         BEQ:     taken = (operand1 == operand2);
         BNE:     taken = (operand1 != operand2);
         BLT:     taken = (op1_s <  op2_s);
         BGE:     taken = (op1_s >= op2_s);
         BLTU:    taken = (operand1 <  operand2);
         BGEU:    taken = (operand1 >= operand2);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch unit: direct-mapped BTB with 2-bit direction counters looked up by the
// fetch PC, plus execute-stage condition resolution, misprediction detection,
// redirect PC generation and table training.
//
// Optional feature macro: STATS_EN (adds saturating br_count / mispred_count).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pc_f                        fetch PC
//   pred_taken_f, pred_target_f prediction for pc_f (combinational)
//   valid_e, stall_e            EX holds a real instruction / EX is stalled
//   branch_type_e               branch type code
//   operand1_e, operand2_e      compare operands
//   pc_e, target_e              EX instruction PC and its computed target
//   pred_taken_e, pred_target_e prediction carried down from fetch
//   branch_e                    resolved taken
//   mispredict_e                redirect required
//   redirect_pc_e               correct next PC
//   br_count, mispred_count     statistics (STATS_EN only)
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_f,
   output logic            pred_taken_f,
   output logic [XLEN-1:0] pred_target_f,
   input  logic            valid_e,
   input  logic            stall_e,
   input  logic [2:0]      branch_type_e,
   input  logic [XLEN-1:0] operand1_e,
   input  logic [XLEN-1:0] operand2_e,
   input  logic [XLEN-1:0] pc_e,
   input  logic [XLEN-1:0] target_e,
   input  logic            pred_taken_e,
   input  logic [XLEN-1:0] pred_target_e,
   output logic            branch_e,
   output logic            mispredict_e,
   output logic [XLEN-1:0] redirect_pc_e
`ifdef STATS_EN
   ,
   output logic [31:0]     br_count,
   output logic [31:0]     mispred_count
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int IDX_LO = 2;
   localparam int TAG_LO = IDX_LO + IDX_W;

   function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
      if (taken) return (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
      else       return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
   endfunction

   // Table storage. valid/cnt are control and reset; tag/target are data and
   // are only meaningful while valid is set.
   logic              valid_q [ENTRIES];
   logic [1:0]        cnt_q   [ENTRIES];
   logic [TAG_W-1:0]  tag_q   [ENTRIES];
   logic [XLEN-1:0]   tgt_q   [ENTRIES];

   logic [IDX_W-1:0]  idx_f, idx_e;
   logic [TAG_W-1:0]  tag_f, tag_e;
   logic              hit_f, hit_e;
   logic              active_e, train_e;
   logic              unused_pc;

   assign idx_f = pc_f[TAG_LO-1:IDX_LO];
   assign tag_f = pc_f[TAG_LO+TAG_W-1:TAG_LO];
   assign idx_e = pc_e[TAG_LO-1:IDX_LO];
   assign tag_e = pc_e[TAG_LO+TAG_W-1:TAG_LO];

   // Bits of the PCs outside index/tag are intentionally ignored.
   assign unused_pc = ^{pc_f, pc_e};

   // Fetch lookup: asynchronous read, no bypass of a same-cycle write.
   assign hit_f         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign pred_taken_f  = hit_f && cnt_q[idx_f][1];
   assign pred_target_f = valid_q[idx_f] ? tgt_q[idx_f] : '0;

   branch_cond #(
      .XLEN(XLEN)
   ) u_cond (
      .branch_type (branch_type_e),
      .operand1    (operand1_e),
      .operand2    (operand2_e),
      .taken       (branch_e)
   );

   assign active_e      = valid_e && (branch_type_e != NOBRANCH);
   assign mispredict_e  = active_e &&
                          ((branch_e != pred_taken_e) ||
                           (branch_e && (pred_target_e != target_e)));
   assign redirect_pc_e = branch_e ? target_e : (pc_e + XLEN'(PC_INCR));

   // A stalled instruction stays in EX, so gating on !stall_e trains it once,
   // in the cycle the stall releases.
   assign train_e = active_e && !stall_e;
   assign hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= CNT_WNT;
         end
      end else if (train_e) begin
         if (hit_e) begin
            cnt_q[idx_e] <= cnt_next(cnt_q[idx_e], branch_e);
         end else if (branch_e) begin
            valid_q[idx_e] <= 1'b1;
            cnt_q[idx_e]   <= CNT_WT;
         end
      end
   end

   // Taken branches refresh the target on a hit and install it on a miss;
   // allocation (miss + taken) also installs the tag.
   always_ff @(posedge clk) begin
      if (!rst && train_e && branch_e) begin
         tgt_q[idx_e] <= target_e;
         if (!hit_e) tag_q[idx_e] <= tag_e;
      end
   end

`ifdef STATS_EN
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else if (train_e) begin
         br_count <= sat_inc32(br_count);
         if (mispredict_e) mispred_count <= sat_inc32(mispred_count);
      end
   end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit.
module tb_branch_predict_unit;
   import branch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_f;
   logic        pred_taken_f;
   logic [31:0] pred_target_f;
   logic        valid_e, stall_e;
   logic [2:0]  branch_type_e;
   logic [31:0] operand1_e, operand2_e, pc_e, target_e, pred_target_e;
   logic        pred_taken_e;
   logic        branch_e, mispredict_e;
   logic [31:0] redirect_pc_e;
`ifdef STATS_EN
   logic [31:0] br_count, mispred_count;
`endif

   int errors = 0;
   int checks = 0;

   branch_predict_unit #(.XLEN(32), .ENTRIES(64), .TAG_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_f          (pc_f),
      .pred_taken_f  (pred_taken_f),
      .pred_target_f (pred_target_f),
      .valid_e       (valid_e),
      .stall_e       (stall_e),
      .branch_type_e (branch_type_e),
      .operand1_e    (operand1_e),
      .operand2_e    (operand2_e),
      .pc_e          (pc_e),
      .target_e      (target_e),
      .pred_taken_e  (pred_taken_e),
      .pred_target_e (pred_target_e),
      .branch_e      (branch_e),
      .mispredict_e  (mispredict_e),
      .redirect_pc_e (redirect_pc_e)
`ifdef STATS_EN
      ,
      .br_count      (br_count),
      .mispred_count (mispred_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic drive_ex(input logic v, input logic s, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] tg,
                           input logic pt, input logic [31:0] ptg);
      valid_e = v; stall_e = s; branch_type_e = t;
      operand1_e = a; operand2_e = b; pc_e = pc; target_e = tg;
      pred_taken_e = pt; pred_target_e = ptg;
   endtask

   task automatic idle_ex();
      drive_ex(1'b0, 1'b0, NOBRANCH, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic test_reset();
      rst = 1'b1; pc_f = 32'h100; idle_ex();
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %0b want 0", pred_taken_f); end
      checks++; if (pred_target_f !== 32'h0) begin errors++; $display("FAIL reset_pred_target: got %h want 00000000", pred_target_f); end
      checks++; if (mispredict_e !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %0b want 0", mispredict_e); end
   endtask

   task automatic test_alloc();
      @(negedge clk); drive_ex(1, 0, BEQ, 5, 5, 32'h100, 32'h140, 0, 0); pc_f = 32'h100; #1;
      checks++; if (branch_e !== 1'b1) begin errors++; $display("FAIL alloc_branch: got %0b want 1", branch_e); end
      checks++; if (mispredict_e !== 1'b1) begin errors++; $display("FAIL alloc_mispredict: got %0b want 1", mispredict_e); end
      checks++; if (redirect_pc_e !== 32'h140) begin errors++; $display("FAIL alloc_redirect: got %h want 00000140", redirect_pc_e); end
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL alloc_no_bypass: got %0b want 0", pred_taken_f); end
      @(negedge clk); idle_ex(); #1;
      checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken: got %0b want 1", pred_taken_f); end
      checks++; if (pred_target_f !== 32'h140) begin errors++; $display("FAIL alloc_pred_target: got %h want 00000140", pred_target_f); end
   endtask

   task automatic test_not_taken();
      // cnt 10 -> 01
      @(negedge clk); drive_ex(1, 0, BEQ, 5, 6, 32'h100, 32'h140, 1, 32'h140); pc_f = 32'h100; #1;
      checks++; if (branch_e !== 1'b0) begin errors++; $display("FAIL nt1_branch: got %0b want 0", branch_e); end
      checks++; if (mispredict_e !== 1'b1) begin errors++; $display("FAIL nt1_mispredict: got %0b want 1", mispredict_e); end
      checks++; if (redirect_pc_e !== 32'h104) begin errors++; $display("FAIL nt1_redirect: got %h want 00000104", redirect_pc_e); end
      @(negedge clk); idle_ex(); #1;
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL nt1_pred_taken: got %0b want 0", pred_taken_f); end
      checks++; if (pred_target_f !== 32'h140) begin errors++; $display("FAIL nt1_pred_target: got %h want 00000140", pred_target_f); end
      // cnt 01 -> 00, prediction agreed
      @(negedge clk); drive_ex(1, 0, BEQ, 7, 8, 32'h100, 32'h140, 0, 0); #1;
      checks++; if (mispredict_e !== 1'b0) begin errors++; $display("FAIL nt2_mispredict: got %0b want 0", mispredict_e); end
      // cnt 00 -> 01: still predicts not-taken, proving the counter reached 00
      @(negedge clk); drive_ex(1, 0, BEQ, 5, 5, 32'h100, 32'h140, 0, 0);
      @(negedge clk); idle_ex(); #1;
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL nt_floor_pred_taken: got %0b want 0", pred_taken_f); end
      // cnt 01 -> 10 with a new target; predicted taken with a stale target
      @(negedge clk); drive_ex(1, 0, BEQ, 9, 9, 32'h100, 32'h180, 1, 32'h140); #1;
      checks++; if (mispredict_e !== 1'b1) begin errors++; $display("FAIL tgt_mismatch_mispredict: got %0b want 1", mispredict_e); end
      checks++; if (redirect_pc_e !== 32'h180) begin errors++; $display("FAIL tgt_mismatch_redirect: got %h want 00000180", redirect_pc_e); end
      @(negedge clk); idle_ex(); #1;
      checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL retrain_pred_taken: got %0b want 1", pred_taken_f); end
      checks++; if (pred_target_f !== 32'h180) begin errors++; $display("FAIL retrain_pred_target: got %h want 00000180", pred_target_f); end
   endtask

   task automatic test_compares();
      logic [2:0]  typ [9];
      logic [31:0] a   [9];
      logic [31:0] b   [9];
      logic        exp [9];
      typ = '{BLT, BLTU, BGEU, BGE, BGE, BNE, BEQ, NOBRANCH, 3'd7};
      a   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'd1, 32'd3, 32'd3, 32'd5, 32'd5};
      b   = '{32'd1, 32'd1, 32'd7, 32'd1, 32'hFFFF_FFFF, 32'd4, 32'd4, 32'd5, 32'd5};
      exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); drive_ex(0, 0, typ[i], a[i], b[i], 32'h200, 32'h240, 0, 0); #1;
         checks++; if (branch_e !== exp[i]) begin errors++; $display("FAIL cmp_%0d_type%0d: got %0b want %0b", i, typ[i], branch_e, exp[i]); end
      end
      @(negedge clk); drive_ex(0, 0, BLT, 32'hFFFF_FFFF, 1, 32'h200, 32'h240, 0, 0); #1;
      checks++; if (mispredict_e !== 1'b0) begin errors++; $display("FAIL inactive_mispredict: got %0b want 0", mispredict_e); end
      checks++; if (redirect_pc_e !== 32'h240) begin errors++; $display("FAIL inactive_redirect: got %h want 00000240", redirect_pc_e); end
      @(negedge clk); drive_ex(0, 0, BEQ, 1, 2, 32'hFFFF_FFFC, 32'h240, 0, 0); #1;
      checks++; if (redirect_pc_e !== 32'h0) begin errors++; $display("FAIL redirect_wrap: got %h want 00000000", redirect_pc_e); end
   endtask

   task automatic test_alias();
      // 0x200 shares index 0 with 0x100 but has tag 0x02
      @(negedge clk); drive_ex(1, 0, BEQ, 1, 1, 32'h200, 32'h300, 0, 0); #1;
      checks++; if (mispredict_e !== 1'b1) begin errors++; $display("FAIL alias_mispredict: got %0b want 1", mispredict_e); end
      @(negedge clk); idle_ex(); pc_f = 32'h100; #1;
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL alias_evicted_taken: got %0b want 0", pred_taken_f); end
      checks++; if (pred_target_f !== 32'h300) begin errors++; $display("FAIL alias_evicted_target: got %h want 00000300", pred_target_f); end
      pc_f = 32'h200; #1;
      checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL alias_new_taken: got %0b want 1", pred_taken_f); end
      checks++; if (pred_target_f !== 32'h300) begin errors++; $display("FAIL alias_new_target: got %h want 00000300", pred_target_f); end
   endtask

   task automatic test_stall();
      // Mid-stream reset with an active taken branch that must not be written.
      @(negedge clk); rst = 1'b1; drive_ex(1, 0, BEQ, 1, 1, 32'h404, 32'h500, 0, 0); pc_f = 32'h404; #1;
      checks++; if (branch_e !== 1'b1) begin errors++; $display("FAIL reset_comb_branch: got %0b want 1", branch_e); end
      @(negedge clk); rst = 1'b0; idle_ex(); pc_f = 32'h200; #1;
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL midreset_pred_taken: got %0b want 0", pred_taken_f); end
      checks++; if (pred_target_f !== 32'h0) begin errors++; $display("FAIL midreset_pred_target: got %h want 00000000", pred_target_f); end
      pc_f = 32'h404; #1;
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL reset_no_write: got %0b want 0", pred_taken_f); end
`ifdef STATS_EN
      checks++; if (br_count !== 32'd0) begin errors++; $display("FAIL stats_reset_br: got %0d want 0", br_count); end
      checks++; if (mispred_count !== 32'd0) begin errors++; $display("FAIL stats_reset_mis: got %0d want 0", mispred_count); end
`endif
      // Taken miss held in stall for 3 cycles.
      @(negedge clk); drive_ex(1, 1, BEQ, 2, 2, 32'h404, 32'h500, 0, 0); #1;
      checks++; if (mispredict_e !== 1'b1) begin errors++; $display("FAIL stall_mispredict: got %0b want 1", mispredict_e); end
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL stall_no_train: got %0b want 0", pred_taken_f); end
      stall_e = 1'b0;
      @(negedge clk); idle_ex(); #1;
      checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL stall_release_taken: got %0b want 1", pred_taken_f); end
      checks++; if (pred_target_f !== 32'h500) begin errors++; $display("FAIL stall_release_target: got %h want 00000500", pred_target_f); end
`ifdef STATS_EN
      checks++; if (br_count !== 32'd1) begin errors++; $display("FAIL stats_stall_br: got %0d want 1", br_count); end
      checks++; if (mispred_count !== 32'd1) begin errors++; $display("FAIL stats_stall_mis: got %0d want 1", mispred_count); end
`endif
      // Single update left cnt at 10; one not-taken gives 01 (a double update would leave 10).
      @(negedge clk); drive_ex(1, 0, BEQ, 1, 2, 32'h404, 32'h500, 1, 32'h500);
      @(negedge clk); idle_ex(); #1;
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL stall_single_update: got %0b want 0", pred_taken_f); end
      // Non-branch must neither mispredict nor touch the table.
      @(negedge clk); drive_ex(1, 0, NOBRANCH, 1, 1, 32'h404, 32'h600, 1, 32'h600); #1;
      checks++; if (mispredict_e !== 1'b0) begin errors++; $display("FAIL nobranch_mispredict: got %0b want 0", mispredict_e); end
      @(negedge clk); idle_ex(); #1;
      checks++; if (pred_target_f !== 32'h500) begin errors++; $display("FAIL nobranch_no_write: got %h want 00000500", pred_target_f); end
`ifdef STATS_EN
      checks++; if (br_count !== 32'd2) begin errors++; $display("FAIL stats_final_br: got %0d want 2", br_count); end
      checks++; if (mispred_count !== 32'd2) begin errors++; $display("FAIL stats_final_mis: got %0d want 2", mispred_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_not_taken();
      test_compares();
      test_alias();
      test_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch unit combining execute-stage condition evaluation with a direct-mapped branch target buffer and 2-bit saturating direction counters. Fetch looks up a prediction by PC; execute resolves the branch condition, flags mispredictions, supplies the redirect PC and trains the table. It sits between the IF-stage next-PC mux and the EX stage, and replaces the purely combinational branch decision logic of earlier cores.

## Interface
- XLEN, 32, operand/PC width
- ENTRIES, 64, BTB entries; power of two, ≥ 2
- TAG_W, 8, stored tag bits taken from the PC above the index
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- pc_f  in  XLEN  fetch PC
- pred_taken_f  out  1  predicted taken for pc_f
- pred_target_f  out  XLEN  predicted target (valid when pred_taken_f)
- valid_e  in  1  EX holds a real instruction (not a bubble or flushed)
- stall_e  in  1  EX is stalled; suppresses training
- branch_type_e  in  3  NOBRANCH/BEQ/BNE/BLT/BLTU/BGE/BGEU
- operand1_e, operand2_e  in  XLEN  compare operands
- pc_e  in  XLEN  PC of the EX instruction
- target_e  in  XLEN  computed branch target
- pred_taken_e, pred_target_e  in  1, XLEN  prediction carried down from IF
- branch_e  out  1  resolved taken
- mispredict_e  out  1  redirect required
- redirect_pc_e  out  XLEN  correct next PC
- br_count, mispred_count  out  32  statistics (only when STATS_EN is defined)

## Operation
- Index = pc[log2(ENTRIES)+1:2]. Tag = the next TAG_W bits above the index.
- Entry fields: valid, tag, cnt[1:0], target. Counter states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Lookup: hit = valid && tag match. pred_taken_f = hit && cnt[1]. pred_target_f = the entry's target; it is 0 when the entry is not valid.
- Resolve: branch_e evaluates the condition for branch_type_e. BLT and BGE use signed compares; BLTU and BGEU use unsigned compares. NOBRANCH and undefined codes give 0.
- Resolution is active when valid_e && branch_type_e != NOBRANCH.
- mispredict_e = active && (branch_e != pred_taken_e || (branch_e && pred_target_e != target_e)). It is 0 when not active.
- redirect_pc_e = branch_e ? target_e : pc_e + 4, computed modulo 2^XLEN.
- Training happens when active && !stall_e:
  - Hit: cnt saturates up if taken, down if not. If taken, the target is overwritten with target_e.
  - Miss and taken: allocate the entry (valid=1, tag, cnt=10, target_e), evicting any previous occupant.
  - Miss and not taken: no change.
- Non-branch instructions never modify the table.

## Timing
- Lookup and resolve paths are combinational (0-cycle). The table uses asynchronous reads from registers.
- Training write takes effect at the posedge after resolution.
- Same-cycle lookup and write to the same index: the lookup returns the pre-write entry. There is no bypass.
- Reset, including mid-stream: every entry has valid=0 and cnt=01; statistics are cleared. After reset, pred_taken_f=0 and pred_target_f=0.
- Combinational outputs follow their inputs during reset. The table is not written in a cycle where rst=1.
- A stall held for N cycles produces exactly one training update, in the cycle stall_e deasserts.

## Configuration
- STATS_EN
  - Defined: br_count increments on each trained branch; mispred_count increments on each trained mispredict. Both saturate at 32'hFFFF_FFFF and are cleared by rst.
  - Not defined: the counters and their ports are absent.

## Structure
- Shared package (branch_pkg):
  - branch type encodings: NOBRANCH=0, BEQ=1, BNE=2, BLT=3, BLTU=4, BGE=5, BGEU=6
  - counter state constants
  - fall-through increment (4)
- One sub-module, branch_cond: the combinational condition evaluator producing branch_e.
- Table storage, lookup and training logic live in the top module.

## Test plan
- Reset, then pc_f=0x100 → pred_taken_f=0, pred_target_f=0.
- BEQ at pc_e=0x100, operands 5/5, target 0x140, pred_taken_e=0:
  - Same cycle: branch_e=1, mispredict_e=1, redirect 0x140.
  - Next cycle: pc_f=0x100 gives pred_taken_f=1, target 0x140.
- Same branch not taken twice:
  - Counter goes 10→01→00.
  - pred_taken_f=0 after the first not-taken.
  - redirect_pc_e=0x104.
- BLT -1 vs 1 → taken. BLTU 0xFFFFFFFF vs 1 → not taken. BGEU equal → taken.
- Two PCs aliasing to one index with different tags: the second allocation evicts the first, and a lookup of the first PC misses.
- stall_e=1 for 3 cycles with an active taken branch: exactly one counter update. With STATS_EN defined: br_count=1, and mispred_count follows the mispredict outcome.
